mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter that shares one single-port synchronous RAM between the pipeline's instruction-fetch port (I) and the MEM-stage data port (D). D normally has priority. A starvation counter forces an I grant after a bounded wait. The block tracks which port owns the in-flight read so that read data returns to the right requester one cycle after the grant. It sits between the IF/MEM stages and the unified memory and drives `i_gnt`, which the hazard logic uses as the inverse of a fetch stall.

## Interface
- `ADDR_W`, 10: RAM word-address width; the RAM holds 2^ADDR_W 32-bit words.
- `STARVE_MAX`, 4: maximum consecutive cycles I may be denied while requesting; range 1..15.

- `clk` input 1: single clock, all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `i_req` input 1: fetch request; held until granted.
- `i_addr` input 32: fetch byte address; bits [1:0] ignored.
- `i_gnt` output 1: fetch accepted this cycle.
- `i_rvalid` output 1: `i_rdata` valid.
- `i_rdata` output 32: fetched instruction.
- `d_req` input 1: data request; held until granted.
- `d_we` input 1: 1 = store, 0 = load.
- `d_addr` input 32: data byte address; bits [1:0] ignored.
- `d_wdata` input 32: store data.
- `d_gnt` output 1: data access accepted this cycle.
- `d_rvalid` output 1: `d_rdata` valid (loads only).
- `d_rdata` output 32: load data.
- `ram_en` output 1: RAM access enable.
- `ram_we` output 1: RAM write enable.
- `ram_addr` output ADDR_W: RAM word address.
- `ram_wdata` output 32: RAM write data.
- `ram_rdata` input 32: RAM read data, valid the cycle after an enabled read.

## Operation
- **Grant logic** (combinational from the current requests and `starve_cnt`):
  - `force_i = i_req && (starve_cnt == STARVE_MAX)`.
  - `d_gnt = d_req && !force_i`.
  - `i_gnt = i_req && !d_gnt`.
  - At most one grant per cycle.
- **RAM drive:**
  - `ram_en = i_gnt | d_gnt`.
  - `ram_we = d_gnt & d_we`.
  - `ram_addr = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2]`.
  - `ram_wdata = d_wdata`.
  - When idle, `ram_addr` = the I address and `ram_we` = 0.
- **Starvation counter** `starve_cnt`, 4 bits:
  - Increments when `i_req && !i_gnt`.
  - Clears when `i_gnt` or `!i_req`.
  - Saturates at `STARVE_MAX`.
- **Read-owner register** `owner`, 2 bits: NONE / I / D. Next value each cycle:
  - D if `d_gnt && !d_we`.
  - I if `i_gnt`.
  - Otherwise NONE.
- **Read return:**
  - `i_rvalid = (owner == I)`; `d_rvalid = (owner == D)`.
  - `i_rdata = d_rdata = ram_rdata`, passed through regardless of owner; consumers qualify with rvalid.
- **Stores:** a store completes at the grant edge and produces no rvalid.
- **Reset:**
  - `owner` = NONE, `starve_cnt` = 0.
  - All rvalid outputs 0.
  - Grants and RAM controls follow the combinational rules immediately after reset.
  - An in-flight read at reset assertion is dropped: no rvalid after release.

## Timing
- Grant latency: 0 cycles; grant is in the same cycle as a request when the request wins.
- Read latency: 1 cycle; rvalid is high exactly in cycle N+1 for a read granted in cycle N.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating ports are allowed, and each gets its own rvalid in the following cycle.
- Simultaneous `i_req` and `d_req`: D wins unless `starve_cnt == STARVE_MAX`, in which case I wins and `starve_cnt` clears on that edge.
- Worst-case I wait under continuous D traffic: STARVE_MAX cycles, with the grant on cycle STARVE_MAX+1.
- Requesters must hold `req`, address and data stable until the grant. Dropping a request before its grant is legal and has no side effects beyond clearing `starve_cnt` when `i_req` drops.
- `d_we` is don't-care when `d_req` = 0.

## Test plan
- **Reset:** assert `rst_n` = 0 with `i_req` = 1 mid-read → `i_rvalid` = 0 and `d_rvalid` = 0 throughout. After release with no requests, no rvalid and `ram_en` = 0.
- **Single fetch:**
  - Stimulus: preload RAM[5] = 0x2008000A; `i_req` = 1, `i_addr` = 0x14, one cycle.
  - Required: `i_gnt` = 1 and `ram_addr` = 5 that cycle; `i_rvalid` = 1 with `i_rdata` = 0x2008000A the next cycle.
- **Conflict, then load:**
  - Stimulus: `i_req` and `d_req` in the same cycle; `d_we` = 0, `d_addr` = 0x40; RAM[16] = 0xDEADBEEF.
  - Required: `d_gnt` = 1, `i_gnt` = 0 that cycle. Next cycle: `d_rvalid` = 1, `d_rdata` = 0xDEADBEEF, `i_rvalid` = 0, and `i_gnt` = 1 if `d_req` has dropped.
- **Store then load:**
  - Stimulus: store 0x12345678 to 0x80, then load 0x80 the next cycle.
  - Required: store cycle has `ram_we` = 1 and `ram_addr` = 32 with no rvalid; load returns 0x12345678 with `d_rvalid` = 1 one cycle later.
- **Starvation (STARVE_MAX = 4):**
  - Stimulus: `d_req` = 1 continuously and `i_req` = 1 from cycle 0.
  - Required: `d_gnt` in cycles 0–3, `i_gnt` in cycle 4 with `d_gnt` = 0, `d_gnt` again in cycles 5–8, `i_gnt` in cycle 9.
- **Back-to-back reads:**
  - Stimulus: fetch in cycle 0, load in cycle 1, fetch in cycle 2.
  - Required: rvalid pattern I, D, I in cycles 1, 2, 3, each with correct data.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, data-port and RAM signal bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requester / RAM side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port synchronous RAM with starvation guard
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] StarveLimit = 4'(STARVE_MAX);

    owner_t     owner;
    owner_t     ownerNext;
    logic [3:0] starveCnt;
    logic [3:0] starveNext;
    logic       forceI;
    logic       iGnt;
    logic       dGnt;

    // Grant decision: D wins unless I has waited the full starvation budget
    always_comb begin
        forceI = bus.i_req && (starveCnt == StarveLimit);
        dGnt   = bus.d_req && !forceI;
        iGnt   = bus.i_req && !dGnt;
    end

    // RAM drive and outputs; read data is passed through, consumers qualify with rvalid
    always_comb begin
        bus.i_gnt     = iGnt;
        bus.d_gnt     = dGnt;
        bus.ram_en    = iGnt | dGnt;
        bus.ram_we    = dGnt & bus.d_we;
        bus.ram_addr  = dGnt ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
        bus.ram_wdata = bus.d_wdata;
        bus.i_rvalid  = (owner == OWN_I);
        bus.d_rvalid  = (owner == OWN_D);
        bus.i_rdata   = bus.ram_rdata;
        bus.d_rdata   = bus.ram_rdata;
    end

    // Next read owner: a store completes at the grant edge and owns no return slot
    always_comb begin
        ownerNext = OWN_NONE;
        if (dGnt && !bus.d_we) begin
            ownerNext = OWN_D;
        end else if (iGnt) begin
            ownerNext = OWN_I;
        end
    end

    // Starvation count: counts denied cycles of a pending fetch, saturating at the limit
    always_comb begin
        starveNext = starveCnt;
        if (!bus.i_req || iGnt) begin
            starveNext = 4'd0;
        end else if (starveCnt != StarveLimit) begin
            starveNext = starveCnt + 4'd1;
        end
    end

    // State registers; reset drops any in-flight read so no rvalid follows release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_NONE;
            starveCnt <= 4'd0;
        end else begin
            owner     <= ownerNext;
            starveCnt <= starveNext;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    // 100 MHz clock
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(10)) bus ();

    mem_arbiter #(.ADDR_W(10), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    // Synchronous single-port RAM model
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        bit          isD;
        logic [31:0] data;
    } ret_t;

    ret_t pending [$];
    int   nAsserts = 0;
    int   nFail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReturn(input string name);
        ret_t e;
        if (pending.size() > 0) begin
            e = pending.pop_front();
            check({name, ":i_rvalid"}, 32'(bus.i_rvalid), 32'(!e.isD));
            check({name, ":d_rvalid"}, 32'(bus.d_rvalid), 32'(e.isD));
            if (e.isD) check({name, ":d_rdata"}, bus.d_rdata, e.data);
            else       check({name, ":i_rdata"}, bus.i_rdata, e.data);
        end else begin
            check({name, ":i_rvalid_idle"}, 32'(bus.i_rvalid), 32'd0);
            check({name, ":d_rvalid_idle"}, 32'(bus.d_rvalid), 32'd0);
        end
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dd,
                        input logic expIg, input logic expDg, input string name);
        logic [9:0] expAddr;
        @(negedge clk);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        #1;
        checkReturn(name);
        expAddr = expDg ? da[11:2] : ia[11:2];
        check({name, ":i_gnt"},    32'(bus.i_gnt),    32'(expIg));
        check({name, ":d_gnt"},    32'(bus.d_gnt),    32'(expDg));
        check({name, ":ram_en"},   32'(bus.ram_en),   32'(expIg | expDg));
        check({name, ":ram_we"},   32'(bus.ram_we),   32'(expDg & dw));
        check({name, ":ram_addr"}, 32'(bus.ram_addr), 32'(expAddr));
        if (expDg && dw) begin
            check({name, ":ram_wdata"}, bus.ram_wdata, dd);
            shadow[expAddr] = dd;
        end else if (expDg) begin
            pending.push_back('{isD: 1'b1, data: shadow[expAddr]});
        end else if (expIg) begin
            pending.push_back('{isD: 1'b0, data: shadow[expAddr]});
        end
    endtask

    // Directed sequence
    initial begin
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'h14;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
        mem[5]  <= 32'h2008000A;  shadow[5]  = 32'h2008000A;
        mem[7]  <= 32'hCAFEF00D;  shadow[7]  = 32'hCAFEF00D;
        mem[16] <= 32'hDEADBEEF;  shadow[16] = 32'hDEADBEEF;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst:i_rvalid", 32'(bus.i_rvalid), 32'd0);
        check("rst:d_rvalid", 32'(bus.d_rvalid), 32'd0);
        check("rst:ram_en",   32'(bus.ram_en),   32'd0);
        rst_n = 1'b1;

        // Fetch, then reset lands while its read is in flight
        step(1, 32'h14, 0, 0, 32'h0, 32'h0, 1, 0, "rst_fetch");
        @(posedge clk);
        #2 rst_n = 1'b0;
        pending.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("rst_mid:i_rvalid", 32'(bus.i_rvalid), 32'd0);
            check("rst_mid:d_rvalid", 32'(bus.d_rvalid), 32'd0);
            check("rst_mid:i_gnt",    32'(bus.i_gnt),    32'd1);
        end
        bus.i_req = 1'b0;
        rst_n     = 1'b1;
        step(0, 32'h14, 0, 0, 32'h0, 32'h0, 0, 0, "post_rst0");
        step(0, 32'h14, 0, 0, 32'h0, 32'h0, 0, 0, "post_rst1");

        // Single fetch
        step(1, 32'h14, 0, 0, 32'h0, 32'h0, 1, 0, "fetch");
        step(0, 32'h14, 0, 0, 32'h0, 32'h0, 0, 0, "fetch_ret");

        // Conflict, then load returns while I gets its grant
        step(1, 32'h14, 1, 0, 32'h40, 32'h0, 0, 1, "conf0");
        step(1, 32'h14, 0, 0, 32'h40, 32'h0, 1, 0, "conf1");
        step(0, 32'h14, 0, 0, 32'h0,  32'h0, 0, 0, "conf2");

        // Store then load of the same word
        step(0, 32'h14, 1, 1, 32'h80, 32'h12345678, 0, 1, "store");
        step(0, 32'h14, 1, 0, 32'h80, 32'h0,        0, 1, "load");
        step(0, 32'h14, 0, 0, 32'h0,  32'h0,        0, 0, "load_ret");

        // Starvation under continuous D traffic
        for (int c = 0; c < 10; c++) begin
            step(1, 32'h14, 1, 0, 32'h40, 32'h0, (c == 4 || c == 9), !(c == 4 || c == 9),
                 $sformatf("starve%0d", c));
        end
        step(0, 32'h14, 0, 0, 32'h0, 32'h0, 0, 0, "starve_end");

        // Back-to-back reads: I, D, I
        step(1, 32'h1C, 0, 0, 32'h0,  32'h0, 1, 0, "b2b0");
        step(0, 32'h1C, 1, 0, 32'h40, 32'h0, 0, 1, "b2b1");
        step(1, 32'h14, 0, 0, 32'h0,  32'h0, 1, 0, "b2b2");
        step(0, 32'h14, 0, 0, 32'h0,  32'h0, 0, 0, "b2b3");
        step(0, 32'h14, 0, 0, 32'h0,  32'h0, 0, 0, "b2b4");

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end
endmodule
